// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
//
// Keeps a shadow copy of the EX, MEM and WB destination/valid state.
// From that state it drives the EX operand-mux selects and the
// load-use stall and bubble controls.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   id_*                  decoded fields of the instruction in ID
//   flush                 taken branch/jump; kills the ID instruction
//   fwd_a_sel, fwd_b_sel  EX operand mux selects (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall                 load-use stall this cycle
//   pc_write_en           PC write enable (~stall)
//   ifid_write_en         IF/ID write enable (~stall)
//   idex_bubble           load a NOP into ID/EX (stall | flush)
//   stall_count           saturating count of stall cycles since reset
module fwd_hazard_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [0:0] {StRun, StStall} state_e;

    state_e state_q, state_d;

    logic             ex_valid_q, ex_uses_rt_q, ex_reg_write_q, ex_mem_read_q;
    logic [REG_W-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
    logic             mem_valid_q, mem_reg_write_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             wb_valid_q, wb_reg_write_q;
    logic [REG_W-1:0] wb_rd_q;
    logic [CNT_W-1:0] stall_count_q;

    logic mem_wr, wb_wr;
    logic hz;

    // A producer only counts if it really writes a non-zero register.
    assign mem_wr = mem_valid_q & mem_reg_write_q & (mem_rd_q != '0);
    assign wb_wr  = wb_valid_q & wb_reg_write_q & (wb_rd_q != '0);

    always_comb begin
        fwd_a_sel = 2'b00;
        if (ex_valid_q && mem_wr && (mem_rd_q == ex_rs_q)) begin
            fwd_a_sel = 2'b01;
        end else if (wb_wr && (wb_rd_q == ex_rs_q)) begin
            fwd_a_sel = 2'b10;
        end
    end

    always_comb begin
        fwd_b_sel = 2'b00;
        if (ex_uses_rt_q) begin
            if (ex_valid_q && mem_wr && (mem_rd_q == ex_rt_q)) begin
                fwd_b_sel = 2'b01;
            end else if (wb_wr && (wb_rd_q == ex_rt_q)) begin
                fwd_b_sel = 2'b10;
            end
        end
    end

    assign hz = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
                ((ex_rd_q == id_rs) | (id_uses_rt & (ex_rd_q == id_rt)));

    // STALL lasts exactly one cycle: by then the load has moved to MEM and
    // the consumer picks its value up from WB.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        unique case (state_q)
            StRun: begin
                stall = hz & ~flush;
                if (stall) begin
                    state_d = StStall;
                end
            end
            StStall: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    assign pc_write_en   = ~stall;
    assign ifid_write_en = ~stall;
    assign idex_bubble   = stall | flush;
    assign stall_count   = stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StRun;
            ex_valid_q      <= 1'b0;
            ex_rs_q         <= '0;
            ex_rt_q         <= '0;
            ex_uses_rt_q    <= 1'b0;
            ex_rd_q         <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            ex_valid_q      <= id_valid & ~stall & ~flush;
            ex_rs_q         <= id_rs;
            ex_rt_q         <= id_rt;
            ex_uses_rt_q    <= id_uses_rt;
            ex_rd_q         <= id_rd;
            ex_reg_write_q  <= id_reg_write;
            ex_mem_read_q   <= id_mem_read;
            mem_valid_q     <= ex_valid_q;
            mem_rd_q        <= ex_rd_q;
            mem_reg_write_q <= ex_reg_write_q;
            wb_valid_q      <= mem_valid_q;
            wb_rd_q         <= mem_rd_q;
            wb_reg_write_q  <= mem_reg_write_q;
            if (stall && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. A second instance with a 2-bit
// counter shares the stimulus to exercise counter saturation.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rt, id_reg_write, id_mem_read, flush;

    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall, pc_write_en, ifid_write_en, idex_bubble;
    logic [15:0] stall_count;

    logic [1:0] fwd_a_sel2, fwd_b_sel2;
    logic       stall2, pc_write_en2, ifid_write_en2, idex_bubble2;
    logic [1:0] stall_count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall(stall), .pc_write_en(pc_write_en),
        .ifid_write_en(ifid_write_en), .idex_bubble(idex_bubble), .stall_count(stall_count)
    );

    fwd_hazard_unit #(.REG_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel2),
        .fwd_b_sel(fwd_b_sel2), .stall(stall2), .pc_write_en(pc_write_en2),
        .ifid_write_en(ifid_write_en2), .idex_bubble(idex_bubble2),
        .stall_count(stall_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urt, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic fl);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        #12 rst_n = 1'b1;
        tick();

        // 1: a completed load-use pair, then reset asserted in mid-stall.
        set_id(1, 5'd1, 5'd0, 0, 5'd2, 1, 1, 0);           // lw $2
        tick();
        set_id(1, 5'd2, 5'd1, 1, 5'd7, 1, 0, 0);           // add $7,$2,$1
        @(negedge clk);
        check("t1_first_stall", stall, 1);
        tick();
        tick();
        idle();
        tick();
        set_id(1, 5'd1, 5'd0, 0, 5'd2, 1, 1, 0);
        tick();
        set_id(1, 5'd2, 5'd1, 1, 5'd7, 1, 0, 0);
        @(negedge clk);
        check("t1_second_stall", stall, 1);
        check("t1_count_pre", stall_count, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t1_rst_stall", stall, 0);
        check("t1_rst_pcwe", pc_write_en, 1);
        check("t1_rst_ifid", ifid_write_en, 1);
        check("t1_rst_bubble", idex_bubble, 0);
        check("t1_rst_fa", fwd_a_sel, 0);
        check("t1_rst_fb", fwd_b_sel, 0);
        check("t1_rst_cnt", stall_count, 0);
        check("t1_rst_cnt2", stall_count2, 0);
        idle();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_idle_fa", fwd_a_sel, 0);
            check("t1_idle_fb", fwd_b_sel, 0);
        end
        tick();

        // 2: back-to-back dependency forwards from EX/MEM on both operands.
        set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);           // add $3,$1,$2
        tick();
        set_id(1, 5'd3, 5'd3, 1, 5'd4, 1, 0, 0);           // add $4,$3,$3
        @(negedge clk);
        check("t2_nostall", stall, 0);
        tick();
        idle();
        @(negedge clk);
        check("t2_fa", fwd_a_sel, 2'b01);
        check("t2_fb", fwd_b_sel, 2'b01);
        drain();

        // 3: distance-two dependency forwards from MEM/WB.
        set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);           // add $3
        tick();
        set_id(1, 5'd9, 5'd10, 1, 5'd8, 1, 0, 0);          // add $8,$9,$10
        tick();
        set_id(1, 5'd6, 5'd3, 1, 5'd5, 1, 0, 0);           // sub $5,$6,$3
        tick();
        idle();
        @(negedge clk);
        check("t3_fa", fwd_a_sel, 2'b00);
        check("t3_fb_wb", fwd_b_sel, 2'b10);
        drain();

        // 3b: middle instruction also writes $3, so MEM wins.
        set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        tick();
        set_id(1, 5'd9, 5'd10, 1, 5'd3, 1, 0, 0);
        tick();
        set_id(1, 5'd6, 5'd3, 1, 5'd5, 1, 0, 0);
        tick();
        idle();
        @(negedge clk);
        check("t3_fb_prio", fwd_b_sel, 2'b01);
        drain();

        // 3c: rt not read, so B never forwards.
        set_id(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        tick();
        set_id(1, 5'd9, 5'd10, 1, 5'd8, 1, 0, 0);
        tick();
        set_id(1, 5'd6, 5'd3, 0, 5'd5, 1, 0, 0);
        tick();
        idle();
        @(negedge clk);
        check("t3_fb_nort", fwd_b_sel, 2'b00);
        drain();

        // 4: load-use gives one bubble, then forwarding from WB.
        set_id(1, 5'd1, 5'd0, 0, 5'd2, 1, 1, 0);           // lw $2
        tick();
        set_id(1, 5'd2, 5'd1, 1, 5'd7, 1, 0, 0);           // add $7,$2,$1
        @(negedge clk);
        check("t4_stall", stall, 1);
        check("t4_bubble", idex_bubble, 1);
        check("t4_pcwe", pc_write_en, 0);
        check("t4_ifid", ifid_write_en, 0);
        tick();
        @(negedge clk);
        check("t4_stall_end", stall, 0);
        check("t4_bubble_end", idex_bubble, 0);
        check("t4_pcwe_end", pc_write_en, 1);
        check("t4_count", stall_count, 1);
        tick();
        idle();
        @(negedge clk);
        check("t4_fa_wb", fwd_a_sel, 2'b10);
        check("t4_fb", fwd_b_sel, 2'b00);
        drain();

        // 5: $0 is never forwarded and never causes a stall.
        set_id(1, 5'd1, 5'd2, 1, 5'd0, 1, 0, 0);           // add $0
        tick();
        set_id(1, 5'd0, 5'd0, 1, 5'd1, 1, 0, 0);           // add $1,$0,$0
        tick();
        idle();
        @(negedge clk);
        check("t5_fa", fwd_a_sel, 2'b00);
        check("t5_fb", fwd_b_sel, 2'b00);
        drain();
        set_id(1, 5'd1, 5'd0, 0, 5'd0, 1, 1, 0);           // lw $0
        tick();
        set_id(1, 5'd0, 5'd0, 1, 5'd4, 1, 0, 0);
        @(negedge clk);
        check("t5_nostall", stall, 0);
        drain();

        // 6: flush beats a simultaneous load-use hazard.
        set_id(1, 5'd1, 5'd0, 0, 5'd2, 1, 1, 0);
        tick();
        set_id(1, 5'd2, 5'd1, 1, 5'd7, 1, 0, 1);
        @(negedge clk);
        check("t6_stall", stall, 0);
        check("t6_bubble", idex_bubble, 1);
        check("t6_pcwe", pc_write_en, 1);
        tick();
        idle();
        @(negedge clk);
        check("t6_count", stall_count, 1);
        check("t6_fa_killed", fwd_a_sel, 2'b00);
        drain();

        // 6b: four more load-use pairs; the 2-bit counter pins at 3.
        for (int i = 0; i < 4; i++) begin
            set_id(1, 5'd1, 5'd0, 0, 5'd2, 1, 1, 0);
            tick();
            set_id(1, 5'd2, 5'd1, 1, 5'd7, 1, 0, 0);
            tick();
            idle();
            @(negedge clk);
            check("t6_cnt16", stall_count, 32'(2 + i));
            check("t6_cnt2", stall_count2, (i >= 1) ? 32'd3 : 32'(2 + i));
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
